// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor controller: counter encodings,
// FSM state type and the 2-bit saturating counter update rule.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} bp_state_t;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST) ? ST : ctr + 2'd1;
    return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_pred_ctrl_if.sv
// Fetch, resolve and IF/ID control signals exchanged between the pipeline
// (master) and the branch predictor controller (slave).
interface branch_pred_ctrl_if #(parameter int CNT_W = 16);

  logic [31:0]      fetch_pc;
  logic             fetch_is_branch;
  logic [31:0]      fetch_target;
  logic             stall_in;
  logic             res_valid;
  logic [31:0]      res_pc;
  logic             res_taken;
  logic             res_pred_taken;
  logic [31:0]      res_target;
  logic             pred_taken;
  logic [1:0]       pred_ctr;
  logic [31:0]      next_pc;
  logic             pc_write_en;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             redirect_valid;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mp_count;

  modport master (
    output fetch_pc, fetch_is_branch, fetch_target, stall_in,
           res_valid, res_pc, res_taken, res_pred_taken, res_target,
    input  pred_taken, pred_ctr, next_pc, pc_write_en, if_id_stall,
           if_id_flush, redirect_valid, br_count, mp_count
  );

  modport slave (
    input  fetch_pc, fetch_is_branch, fetch_target, stall_in,
           res_valid, res_pc, res_taken, res_pred_taken, res_target,
    output pred_taken, pred_ctr, next_pc, pc_write_en, if_id_stall,
           if_id_flush, redirect_valid, br_count, mp_count
  );

endinterface

// File: rtl/bht_2bit.sv
// Table of 2-bit saturating branch-history counters with one asynchronous
// read port and one synchronous update port; reset sets every entry weakly not-taken.
module bht_2bit
  import bp_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0] ctr_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ctr_mem[i] <= WNT;
    end else if (upd_en) begin
      ctr_mem[upd_idx] <= sat_update(ctr_mem[upd_idx], upd_taken);
    end
  end

  // Read returns the pre-update value when the same entry is written this cycle.
  assign rd_ctr = ctr_mem[rd_idx];

endmodule

// File: rtl/branch_pred_ctrl.sv
// Fetch-side branch prediction and mispredict recovery controller driving the
// PC register and the IF/ID pipeline register.
module branch_pred_ctrl
  import bp_pkg::*;
#(
  parameter int IDX_W     = 4,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input logic               clk,
  input logic               rst,
  branch_pred_ctrl_if.slave bus
);

  // The mispredict cycle is itself the first flush cycle, so FLUSH lasts FLUSH_CYC-1 cycles.
  localparam logic [2:0] RELOAD = (FLUSH_CYC >= 2) ? 3'(FLUSH_CYC - 2) : 3'd0;

  bp_state_t        state_q;
  logic [2:0]       cnt_q;
  logic [CNT_W-1:0] br_q;
  logic [CNT_W-1:0] mp_q;
  logic [1:0]       ctr;
  logic             mp;
  logic             pred_taken;
  logic             stall;
  logic [31:0]      npc;

  bht_2bit #(.IDX_W(IDX_W)) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (bus.fetch_pc[IDX_W+1:2]),
    .rd_ctr    (ctr),
    .upd_en    (bus.res_valid),
    .upd_idx   (bus.res_pc[IDX_W+1:2]),
    .upd_taken (bus.res_taken)
  );

  assign mp = bus.res_valid & (bus.res_taken != bus.res_pred_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (mp && FLUSH_CYC > 1) begin
            state_q <= FLUSH;
            cnt_q   <= RELOAD;
          end
        end
        FLUSH: begin
          if (mp)               cnt_q   <= RELOAD;
          else if (cnt_q == 0)  state_q <= RUN;
          else                  cnt_q   <= cnt_q - 3'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      if (bus.res_valid && br_q != '1) br_q <= br_q + 1'b1;
      if (mp && mp_q != '1)            mp_q <= mp_q + 1'b1;
    end
  end

  // A mispredict redirect outranks both the prediction and a load-use stall.
  always_comb begin
    pred_taken = bus.fetch_is_branch & ctr[1] & (state_q == RUN);
    stall      = bus.stall_in & ~mp;
    if (mp)              npc = bus.res_taken ? bus.res_target : bus.res_pc + 32'd4;
    else if (pred_taken) npc = bus.fetch_target;
    else                 npc = bus.fetch_pc + 32'd4;
  end

  assign bus.pred_taken     = pred_taken;
  assign bus.pred_ctr       = ctr;
  assign bus.next_pc        = npc;
  assign bus.pc_write_en    = ~stall;
  assign bus.if_id_stall    = stall;
  assign bus.if_id_flush    = mp | (state_q == FLUSH);
  assign bus.redirect_valid = mp;
  assign bus.br_count       = br_q;
  assign bus.mp_count       = mp_q;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Randomized and directed bench for branch_pred_ctrl, checking two configurations
// against a behavioural model of the prediction table, recovery window and statistics.
module tb_branch_pred_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_pred_ctrl_if #(.CNT_W(16)) bus0 ();
  branch_pred_ctrl_if #(.CNT_W(4))  bus1 ();

  branch_pred_ctrl #(.IDX_W(4), .FLUSH_CYC(3), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  branch_pred_ctrl #(.IDX_W(4), .FLUSH_CYC(1), .CNT_W(4))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int total = 0;
  int bad   = 0;

  logic [31:0] s_fpc, s_ftgt, s_rpc, s_rtgt;
  logic        s_fbr, s_stl, s_rv, s_rt, s_rpt;

  // Model: counter value per entry, remaining flush cycles after the current one, counts.
  int  m_tbl [2][16];
  int  m_left [2];
  int  m_br [2];
  int  m_mp [2];
  bit  m_init = 0;

  function automatic int fcOf(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  function automatic int cmaxOf(input int d);
    return (d == 0) ? 65535 : 15;
  endfunction

  function automatic int idxOf(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] fpc, input logic fbr, input logic [31:0] ftgt,
                               input logic stl, input logic rv, input logic [31:0] rpc,
                               input logic rt, input logic rpt, input logic [31:0] rtgt);
    s_fpc = fpc; s_fbr = fbr; s_ftgt = ftgt; s_stl = stl;
    s_rv = rv; s_rpc = rpc; s_rt = rt; s_rpt = rpt; s_rtgt = rtgt;
    bus0.fetch_pc = fpc; bus0.fetch_is_branch = fbr; bus0.fetch_target = ftgt; bus0.stall_in = stl;
    bus0.res_valid = rv; bus0.res_pc = rpc; bus0.res_taken = rt; bus0.res_pred_taken = rpt;
    bus0.res_target = rtgt;
    bus1.fetch_pc = fpc; bus1.fetch_is_branch = fbr; bus1.fetch_target = ftgt; bus1.stall_in = stl;
    bus1.res_valid = rv; bus1.res_pc = rpc; bus1.res_taken = rt; bus1.res_pred_taken = rpt;
    bus1.res_target = rtgt;
  endtask

  task automatic idle(input logic [31:0] fpc, input logic fbr);
    applyStimulus(fpc, fbr, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic checkDut(input int d, input logic pt, input logic [1:0] pc, input logic [31:0] npc,
                          input logic pwe, input logic stl, input logic fl, input logic rd,
                          input logic [31:0] brc, input logic [31:0] mpc);
    string p;
    int ectr;
    bit infl, ept, emp, estl;
    logic [31:0] enpc;
    if (!m_init) return;
    p    = (d == 0) ? "fc3" : "fc1";
    infl = m_left[d] > 0;
    ectr = m_tbl[d][idxOf(s_fpc)];
    ept  = s_fbr && ectr >= 2 && !infl;
    emp  = s_rv && (s_rt != s_rpt);
    estl = s_stl && !emp;
    if (emp)      enpc = s_rt ? s_rtgt : s_rpc + 32'd4;
    else if (ept) enpc = s_ftgt;
    else          enpc = s_fpc + 32'd4;
    checkOutput({p, " pred_ctr"},       32'(pc),  32'(ectr));
    checkOutput({p, " pred_taken"},     32'(pt),  32'(ept));
    checkOutput({p, " next_pc"},        npc,      enpc);
    checkOutput({p, " if_id_stall"},    32'(stl), 32'(estl));
    checkOutput({p, " pc_write_en"},    32'(pwe), 32'(!estl));
    checkOutput({p, " if_id_flush"},    32'(fl),  32'(emp || infl));
    checkOutput({p, " redirect_valid"}, 32'(rd),  32'(emp));
    checkOutput({p, " br_count"},       brc,      32'(m_br[d]));
    checkOutput({p, " mp_count"},       mpc,      32'(m_mp[d]));
  endtask

  task automatic modelUpdate();
    bit emp;
    int k;
    emp = s_rv && (s_rt != s_rpt);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) m_tbl[d][i] = 1;
        m_left[d] = 0; m_br[d] = 0; m_mp[d] = 0;
      end else begin
        if (s_rv) begin
          k = idxOf(s_rpc);
          if (s_rt) m_tbl[d][k] = (m_tbl[d][k] < 3) ? m_tbl[d][k] + 1 : 3;
          else      m_tbl[d][k] = (m_tbl[d][k] > 0) ? m_tbl[d][k] - 1 : 0;
          if (m_br[d] < cmaxOf(d)) m_br[d]++;
        end
        if (emp) begin
          if (m_mp[d] < cmaxOf(d)) m_mp[d]++;
          m_left[d] = fcOf(d) - 1;
        end else if (m_left[d] > 0) begin
          m_left[d]--;
        end
      end
    end
    if (rst) m_init = 1;
  endtask

  task automatic doCycle();
    @(negedge clk);
    checkDut(0, bus0.pred_taken, bus0.pred_ctr, bus0.next_pc, bus0.pc_write_en, bus0.if_id_stall,
             bus0.if_id_flush, bus0.redirect_valid, 32'(bus0.br_count), 32'(bus0.mp_count));
    checkDut(1, bus1.pred_taken, bus1.pred_ctr, bus1.next_pc, bus1.pc_write_en, bus1.if_id_stall,
             bus1.if_id_flush, bus1.redirect_valid, 32'(bus1.br_count), 32'(bus1.mp_count));
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle(32'h0, 1'b0);
    doCycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle(32'h0, 1'b0);
    @(posedge clk);
    #1;
    doReset();

    // Fresh table predicts weakly not-taken.
    idle(32'h40, 1'b1);
    #1;
    checkOutput("plan reset pred_ctr", 32'(bus0.pred_ctr), 32'h1);
    checkOutput("plan reset pred_taken", 32'(bus0.pred_taken), 32'h0);
    checkOutput("plan reset next_pc", bus0.next_pc, 32'h44);
    checkOutput("plan reset flush", 32'(bus0.if_id_flush), 32'h0);
    doCycle();

    // Train 0x40 taken twice, then saturate, then one not-taken.
    repeat (2) begin
      applyStimulus(32'h40, 1'b1, 32'h80, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 32'h80);
      doCycle();
    end
    idle(32'h40, 1'b1);
    #1;
    checkOutput("plan trained pred_ctr", 32'(bus0.pred_ctr), 32'h3);
    checkOutput("plan trained pred_taken", 32'(bus0.pred_taken), 32'h1);
    checkOutput("plan trained next_pc", bus0.next_pc, 32'h80);
    doCycle();
    applyStimulus(32'h40, 1'b1, 32'h80, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 32'h80);
    doCycle();
    applyStimulus(32'h40, 1'b1, 32'h80, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h80);
    doCycle();
    idle(32'h40, 1'b1);
    #1;
    checkOutput("plan decay pred_ctr", 32'(bus0.pred_ctr), 32'h2);
    doCycle();

    // Taken mispredict opens a three-cycle flush window on the FLUSH_CYC=3 instance.
    doReset();
    applyStimulus(32'h100, 1'b1, 32'h300, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200);
    #1;
    checkOutput("plan mp redirect", 32'(bus0.redirect_valid), 32'h1);
    checkOutput("plan mp next_pc", bus0.next_pc, 32'h200);
    doCycle();
    for (int c = 0; c < 3; c++) begin
      idle(32'h100, 1'b1);
      #1;
      checkOutput($sformatf("plan flush window %0d", c), 32'(bus0.if_id_flush), (c < 2) ? 32'h1 : 32'h0);
      checkOutput($sformatf("plan flush pred_taken %0d", c), 32'(bus0.pred_taken), (c < 2) ? 32'h0 : 32'h1);
      doCycle();
    end
    checkOutput("plan mp_count", 32'(bus0.mp_count), 32'h1);
    checkOutput("plan br_count", 32'(bus0.br_count), 32'h1);

    // Stall arbitration.
    applyStimulus(32'h8, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("plan stall alone", 32'(bus0.if_id_stall), 32'h1);
    checkOutput("plan stall pc_write_en", 32'(bus0.pc_write_en), 32'h0);
    doCycle();
    applyStimulus(32'h8, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b0, 1'b1, 32'h0);
    #1;
    checkOutput("plan stall vs mp stall", 32'(bus0.if_id_stall), 32'h0);
    checkOutput("plan stall vs mp flush", 32'(bus0.if_id_flush), 32'h1);
    checkOutput("plan stall vs mp pc_write_en", 32'(bus0.pc_write_en), 32'h1);
    doCycle();

    // Not-taken mispredict at the top of the address space wraps to zero.
    applyStimulus(32'h8, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1234);
    #1;
    checkOutput("plan wrap next_pc", bus0.next_pc, 32'h0);
    doCycle();

    // Reset during the second flush cycle abandons recovery.
    repeat (3) begin idle(32'h8, 1'b0); doCycle(); end
    applyStimulus(32'h8, 1'b0, 32'h0, 1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h400);
    doCycle();
    doReset();
    idle(32'h8, 1'b0);
    #1;
    checkOutput("plan rst flush", 32'(bus0.if_id_flush), 32'h0);
    checkOutput("plan rst br_count", 32'(bus0.br_count), 32'h0);
    checkOutput("plan rst mp_count", 32'(bus0.mp_count), 32'h0);
    for (int i = 0; i < 16; i++) begin
      idle(32'(i * 4), 1'b1);
      #1;
      checkOutput($sformatf("plan rst entry %0d", i), 32'(bus0.pred_ctr), 32'h1);
    end
    doCycle();

    // Random traffic against the model, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 15)) * 32'd4;
      rst = ($urandom_range(0, 79) == 0);
      applyStimulus($urandom & 32'hFFFF_FFFC, 1'($urandom), $urandom & 32'hFFFF_FFFC,
                    ($urandom_range(0, 3) == 0), 1'($urandom), rpc, 1'($urandom),
                    1'($urandom), $urandom & 32'hFFFF_FFFC);
      doCycle();
    end
    rst = 1'b0;

    // Statistics saturate on the narrow-counter instance.
    doReset();
    repeat (20) begin
      applyStimulus(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h40);
      doCycle();
    end
    idle(32'h0, 1'b0);
    #1;
    checkOutput("plan br_count saturate", 32'(bus1.br_count), 32'hF);
    checkOutput("plan mp_count saturate", 32'(bus1.mp_count), 32'hF);
    doCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
